// File: rtl/generador_cuenta_vga_pkg.sv
// Shared 640x480@60 timing defaults, derived totals and the decode record
// used by the pixel-count generator and its counters.
package generador_cuenta_vga_pkg;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   localparam int CNT_W = 11;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_on;
   } decod_t;

   // Width able to hold 0..n-1; never below one bit so a divide-by-1 still elaborates
   function automatic int ancho_cuenta(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/generador_cuenta_vga_contador.sv
// Modulo-N counter with enable; exposes the registered count, the value it
// will take on the next edge, and a terminal-count flag.
module contador_modulo #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_en,
   output logic [W-1:0] o_cuenta,
   output logic [W-1:0] o_siguiente,
   output logic         o_tc
);

   localparam logic [W-1:0] MAXIMO = W'(N - 1);

   logic [W-1:0] r_cuenta;
   logic [W-1:0] w_siguiente;

   assign o_tc = (r_cuenta == MAXIMO);

   always_comb begin
      w_siguiente = r_cuenta;
      if (i_en)
         w_siguiente = o_tc ? '0 : r_cuenta + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cuenta <= '0;
      else
         r_cuenta <= w_siguiente;
   end

   assign o_cuenta    = r_cuenta;
   assign o_siguiente = w_siguiente;

endmodule

// File: rtl/generador_cuenta_vga.sv
// VGA pixel-timing generator: prescaled pixel tick, horizontal/vertical
// counts, registered sync/video decode and an end-of-frame pulse.
module generador_cuenta_vga
   import generador_cuenta_vga_pkg::*;
#(
   parameter int   CLK_DIV   = 2,
   parameter int   H_VISIBLE = H_VISIBLE_DEF,
   parameter int   H_FRONT   = H_FRONT_DEF,
   parameter int   H_SYNC    = H_SYNC_DEF,
   parameter int   H_BACK    = H_BACK_DEF,
   parameter int   V_VISIBLE = V_VISIBLE_DEF,
   parameter int   V_FRONT   = V_FRONT_DEF,
   parameter int   V_SYNC    = V_SYNC_DEF,
   parameter int   V_BACK    = V_BACK_DEF,
   parameter logic SYNC_POL  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             habilitar,
   output logic             pixel_tick,
   output logic [CNT_W-1:0] hcont,
   output logic [CNT_W-1:0] vcont,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic             fin_cuadro
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int PW      = ancho_cuenta(CLK_DIV);

   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] HS_INI   = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_FIN   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] VS_INI   = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_FIN   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [PW-1:0]    w_unused_presc_cuenta;
   logic [PW-1:0]    w_unused_presc_sig;
   logic             w_presc_tc;
   logic             w_h_tc;
   logic             w_v_tc;
   logic [CNT_W-1:0] w_h_sig;
   logic [CNT_W-1:0] w_v_sig;
   decod_t           w_dec;
   decod_t           r_dec;

   contador_modulo #(.N(CLK_DIV), .W(PW)) u_prescaler (
      .clk         (clk),
      .rst         (reset),
      .i_en        (habilitar),
      .o_cuenta    (w_unused_presc_cuenta),
      .o_siguiente (w_unused_presc_sig),
      .o_tc        (w_presc_tc)
   );

   // Reset gating keeps the tick low while held in reset, which matters for CLK_DIV=1
   assign pixel_tick = habilitar & w_presc_tc & ~reset;
   assign fin_cuadro = pixel_tick & w_h_tc & w_v_tc;

   contador_modulo #(.N(H_TOTAL), .W(CNT_W)) u_hcont (
      .clk         (clk),
      .rst         (reset),
      .i_en        (pixel_tick),
      .o_cuenta    (hcont),
      .o_siguiente (w_h_sig),
      .o_tc        (w_h_tc)
   );

   contador_modulo #(.N(V_TOTAL), .W(CNT_W)) u_vcont (
      .clk         (clk),
      .rst         (reset),
      .i_en        (pixel_tick & w_h_tc),
      .o_cuenta    (vcont),
      .o_siguiente (w_v_sig),
      .o_tc        (w_v_tc)
   );

   // Decoding the next counts lets the registered syncs move on the same edge as the counts
   always_comb begin
      w_dec          = '0;
      w_dec.hsync    = ((w_h_sig >= HS_INI) && (w_h_sig < HS_FIN)) ? SYNC_POL : ~SYNC_POL;
      w_dec.vsync    = ((w_v_sig >= VS_INI) && (w_v_sig < VS_FIN)) ? SYNC_POL : ~SYNC_POL;
      w_dec.video_on = (w_h_sig < H_VIS) && (w_v_sig < V_VIS);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dec.hsync    <= ~SYNC_POL;
         r_dec.vsync    <= ~SYNC_POL;
         r_dec.video_on <= 1'b0;
      end else begin
         r_dec <= w_dec;
      end
   end

   assign hsync    = r_dec.hsync;
   assign vsync    = r_dec.vsync;
   assign video_on = r_dec.video_on;

endmodule

// File: tb/tb_generador_cuenta_vga.sv
// Directed bench: default 640x480 timing at CLK_DIV=2, plus a tiny-frame
// CLK_DIV=1, positive-sync build for frame wrap and end-of-frame spacing.
module tb_generador_cuenta_vga;

   logic        clk = 1'b0;
   logic        reset, habilitar;
   logic        pixel_tick, hsync, vsync, video_on, fin_cuadro;
   logic [10:0] hcont, vcont;

   logic        c_reset, c_habilitar;
   logic        c_pixel_tick, c_hsync, c_vsync, c_video_on, c_fin_cuadro;
   logic [10:0] c_hcont, c_vcont;

   int pruebas = 0;
   int fallos  = 0;

   always #5 clk = ~clk;

   generador_cuenta_vga #(.CLK_DIV(2)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .habilitar  (habilitar),
      .pixel_tick (pixel_tick),
      .hcont      (hcont),
      .vcont      (vcont),
      .hsync      (hsync),
      .vsync      (vsync),
      .video_on   (video_on),
      .fin_cuadro (fin_cuadro)
   );

   // 8 x 6 frame: hsync active at h=5..6, vsync active at v=4, syncs active-high
   generador_cuenta_vga #(
      .CLK_DIV(1), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b1)
   ) u_chico (
      .clk        (clk),
      .reset      (c_reset),
      .habilitar  (c_habilitar),
      .pixel_tick (c_pixel_tick),
      .hcont      (c_hcont),
      .vcont      (c_vcont),
      .hsync      (c_hsync),
      .vsync      (c_vsync),
      .video_on   (c_video_on),
      .fin_cuadro (c_fin_cuadro)
   );

   task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      pruebas++;
      if (obs !== esp) begin
         fallos++;
         $display("FAIL %s: observado=%0d esperado=%0d", tag, obs, esp);
      end
   endtask

   task automatic ir_a(input bit chico, input int h, input int v, input int limite);
      int  n  = 0;
      bit  ok = 1'b0;
      while (n < limite && !ok) begin
         @(negedge clk);
         n++;
         if (chico) ok = (c_hcont == 11'(h)) && (c_vcont == 11'(v));
         else       ok = (hcont == 11'(h)) && (vcont == 11'(v));
      end
      comprobar($sformatf("alcanza_%0d_%0d", h, v), 32'(ok), 1);
   endtask

   initial begin
      int n;
      reset = 1'b1; habilitar = 1'b1;
      c_reset = 1'b1; c_habilitar = 1'b1;

      // reset values, default build
      repeat (3) @(posedge clk);
      @(negedge clk);
      comprobar("rst_hcont", hcont, 0);
      comprobar("rst_vcont", vcont, 0);
      comprobar("rst_tick", pixel_tick, 0);
      comprobar("rst_video", video_on, 0);
      comprobar("rst_hsync", hsync, 1);
      comprobar("rst_vsync", vsync, 1);
      comprobar("rst_fin", fin_cuadro, 0);

      reset = 1'b0;
      comprobar("rel_tick0", pixel_tick, 0);
      @(negedge clk);
      comprobar("e1_tick", pixel_tick, 1);
      comprobar("e1_hcont", hcont, 0);
      comprobar("e1_video", video_on, 1);
      comprobar("e1_hsync", hsync, 1);
      comprobar("e1_vsync", vsync, 1);
      @(negedge clk);
      comprobar("e2_tick", pixel_tick, 0);
      comprobar("e2_hcont", hcont, 1);
      @(negedge clk);
      comprobar("e3_tick", pixel_tick, 1);
      @(negedge clk);
      comprobar("e4_tick", pixel_tick, 0);
      comprobar("e4_hcont", hcont, 2);

      // one line
      ir_a(0, 639, 0, 4000); comprobar("h639_video", video_on, 1);
      ir_a(0, 640, 0, 4000); comprobar("h640_video", video_on, 0);
      ir_a(0, 655, 0, 4000); comprobar("h655_hsync", hsync, 1);
      ir_a(0, 656, 0, 4000); comprobar("h656_hsync", hsync, 0);
      ir_a(0, 751, 0, 4000); comprobar("h751_hsync", hsync, 0);
      ir_a(0, 752, 0, 4000); comprobar("h752_hsync", hsync, 1);
      ir_a(0, 799, 0, 4000);
      comprobar("h799_video", video_on, 0);
      comprobar("h799_fin_a", fin_cuadro, 0);
      @(negedge clk);
      comprobar("h799_tick", pixel_tick, 1);
      comprobar("h799_fin_b", fin_cuadro, 0);
      ir_a(0, 0, 1, 10);
      comprobar("v1_video", video_on, 1);
      comprobar("v1_vsync", vsync, 1);

      // enable drop at hcont=100
      ir_a(0, 100, 1, 4000);
      habilitar = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         comprobar($sformatf("pausa_hcont_%0d", i), hcont, 100);
         comprobar($sformatf("pausa_tick_%0d", i), pixel_tick, 0);
      end
      comprobar("pausa_video", video_on, 1);
      habilitar = 1'b1;
      #1 comprobar("reanuda_tick0", pixel_tick, 0);
      @(negedge clk);
      comprobar("reanuda_tick1", pixel_tick, 1);
      comprobar("reanuda_h100", hcont, 100);
      @(negedge clk);
      comprobar("reanuda_h101", hcont, 101);

      // asynchronous reset mid-line
      ir_a(0, 300, 1, 4000);
      #2 reset = 1'b1;
      #1;
      comprobar("arst_hcont", hcont, 0);
      comprobar("arst_vcont", vcont, 0);
      comprobar("arst_video", video_on, 0);
      comprobar("arst_hsync", hsync, 1);
      comprobar("arst_vsync", vsync, 1);
      comprobar("arst_tick", pixel_tick, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      comprobar("arst_e1_tick", pixel_tick, 1);
      comprobar("arst_e1_hcont", hcont, 0);
      @(negedge clk);
      comprobar("arst_e2_hcont", hcont, 1);

      // small build, CLK_DIV=1, positive syncs
      comprobar("c_rst_tick", c_pixel_tick, 0);
      comprobar("c_rst_hsync", c_hsync, 0);
      comprobar("c_rst_vsync", c_vsync, 0);
      comprobar("c_rst_video", c_video_on, 0);
      c_reset = 1'b0;
      @(negedge clk);
      comprobar("c_e1_tick", c_pixel_tick, 1);
      comprobar("c_e1_hcont", c_hcont, 1);
      comprobar("c_e1_video", c_video_on, 1);
      @(negedge clk);
      comprobar("c_e2_tick", c_pixel_tick, 1);
      comprobar("c_e2_hcont", c_hcont, 2);
      ir_a(1, 4, 0, 50); comprobar("c_h4_video", c_video_on, 0);
      comprobar("c_h4_hsync", c_hsync, 0);
      ir_a(1, 5, 0, 50); comprobar("c_h5_hsync", c_hsync, 1);
      ir_a(1, 6, 0, 50); comprobar("c_h6_hsync", c_hsync, 1);
      ir_a(1, 7, 0, 50); comprobar("c_h7_hsync", c_hsync, 0);
      ir_a(1, 0, 3, 50); comprobar("c_v3_vsync", c_vsync, 0);
      ir_a(1, 0, 4, 50); comprobar("c_v4_vsync", c_vsync, 1);
      ir_a(1, 0, 5, 50); comprobar("c_v5_vsync", c_vsync, 0);
      ir_a(1, 7, 5, 50);
      comprobar("c_fin_pulso", c_fin_cuadro, 1);
      @(negedge clk);
      comprobar("c_wrap_h", c_hcont, 0);
      comprobar("c_wrap_v", c_vcont, 0);
      comprobar("c_wrap_fin", c_fin_cuadro, 0);
      n = 0;
      while (n < 200 && !c_fin_cuadro) begin
         @(negedge clk);
         n++;
      end
      comprobar("c_fin_intervalo", 32'(n + 1), 48);

      c_habilitar = 1'b0;
      #1;
      comprobar("c_pausa_tick", c_pixel_tick, 0);
      comprobar("c_pausa_fin", c_fin_cuadro, 0);
      repeat (3) @(negedge clk);
      comprobar("c_pausa_h", c_hcont, 7);
      comprobar("c_pausa_v", c_vcont, 5);
      c_habilitar = 1'b1;
      @(negedge clk);
      comprobar("c_reanuda_h", c_hcont, 0);
      comprobar("c_reanuda_v", c_vcont, 0);

      $display("[TB] %0d tests run, %0d failed", pruebas, fallos);
      $finish;
   end

endmodule
